// File: rtl/vrf_read_sequencer_if.sv
// Request, VRF read port and operand stream bundle for vrf_read_sequencer.
// master = sequencer side, slave = request source / VRF / operand consumer side.
interface vrf_read_sequencer_if #(
  parameter int ADDR_W    = 9,
  parameter int MEM_WIDTH = 32,
  parameter int LEN_W     = ADDR_W + 1
);
  logic                 req_valid_i;
  logic                 req_ready_o;
  logic [ADDR_W-1:0]    req_base_i;
  logic [LEN_W-1:0]     req_len_i;
  logic [ADDR_W-1:0]    raddr_o;
  logic                 ren_o;
  logic                 oreg_en_o;
  logic [MEM_WIDTH-1:0] dout_i;
  logic                 data_valid_o;
  logic [MEM_WIDTH-1:0] data_o;
  logic                 data_last_o;
  logic                 data_ready_i;
  logic                 busy_o;

  modport master (
    input  req_valid_i, req_base_i, req_len_i, dout_i, data_ready_i,
    output req_ready_o, raddr_o, ren_o, oreg_en_o,
           data_valid_o, data_o, data_last_o, busy_o
  );

  modport slave (
    output req_valid_i, req_base_i, req_len_i, dout_i, data_ready_i,
    input  req_ready_o, raddr_o, ren_o, oreg_en_o,
           data_valid_o, data_o, data_last_o, busy_o
  );
endinterface

// File: rtl/vrf_read_sequencer.sv
// Burst reader for one VRF read port: one read per cycle, first beat 2+VRF_READ_DELAY cycles after accept.
// Reads are credit-throttled so the output FIFO can absorb every in-flight word under stream backpressure.
module vrf_read_sequencer #(
  parameter int MEM_DEPTH      = 512,
  parameter int MEM_WIDTH      = 32,
  parameter int VRF_READ_DELAY = 4,
  parameter int FIFO_DEPTH     = 8,
  parameter int ADDR_W         = $clog2(MEM_DEPTH),
  parameter int LEN_W          = ADDR_W + 1
) (
  input  logic                clk,
  input  logic                rstn,
  vrf_read_sequencer_if.master bus
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = MEM_WIDTH + 1;

  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(MEM_DEPTH - 1);
  localparam logic [LEN_W-1:0]  LEN_ONE   = LEN_W'(1);
  localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t              state;
  logic [ADDR_W-1:0]   raddr_q;
  logic                ren_q;
  logic [LEN_W-1:0]    remaining;

  logic [VRF_READ_DELAY-1:0] sh_vld;
  logic [VRF_READ_DELAY-1:0] sh_last;

  logic [ENT_W-1:0]    fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    rd_ptr;
  logic [PTR_W-1:0]    wr_ptr;
  logic [CNT_W-1:0]    fifo_count;

  logic                fifo_empty;
  logic                fifo_full;
  logic [ENT_W-1:0]    head;
  logic                push;
  logic                pop;
  logic                issue_last;
  logic                credit_ok;
  int                  inflight_cnt;
  int                  outstanding;

  assign fifo_empty = (fifo_count == '0);
  assign fifo_full  = (fifo_count == CNT_FULL);
  assign head       = fifo_mem[rd_ptr];
  assign push       = sh_vld[VRF_READ_DELAY-1];
  assign pop        = !fifo_empty && bus.data_ready_i;
  assign issue_last = ren_q && (remaining == LEN_ONE);

  // Words that will still hold a FIFO slot or be in flight after this edge; a new read
  // may only be launched if that leaves room for it.
  always_comb begin
    inflight_cnt = 0;
    for (int i = 0; i < VRF_READ_DELAY; i++) begin
      inflight_cnt = inflight_cnt + int'(sh_vld[i]);
    end
    outstanding = int'(fifo_count) + inflight_cnt + int'(ren_q) - int'(pop);
    credit_ok   = (outstanding < FIFO_DEPTH);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= IDLE;
      raddr_q   <= '0;
      ren_q     <= 1'b0;
      remaining <= '0;
    end else begin
      case (state)
        IDLE: begin
          ren_q <= 1'b0;
          if (bus.req_valid_i) begin
            raddr_q   <= bus.req_base_i;
            remaining <= bus.req_len_i;
            if (bus.req_len_i != '0) begin
              state <= ISSUE;
              ren_q <= credit_ok;
            end
          end
        end
        ISSUE: begin
          if (ren_q) begin
            raddr_q   <= (raddr_q == ADDR_LAST) ? '0 : raddr_q + ADDR_ONE;
            remaining <= remaining - LEN_ONE;
          end
          if (issue_last) begin
            state <= DRAIN;
            ren_q <= 1'b0;
          end else begin
            ren_q <= credit_ok;
          end
        end
        DRAIN: begin
          ren_q <= 1'b0;
          if (pop && head[MEM_WIDTH]) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          ren_q <= 1'b0;
        end
      endcase
    end
  end

  // Stage VRF_READ_DELAY-1 lines up with the cycle in which dout_i carries that read's word.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      sh_vld  <= '0;
      sh_last <= '0;
    end else begin
      sh_vld[0]  <= ren_q;
      sh_last[0] <= issue_last;
      for (int i = 1; i < VRF_READ_DELAY; i++) begin
        sh_vld[i]  <= sh_vld[i-1];
        sh_last[i] <= sh_last[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= {sh_last[VRF_READ_DELAY-1], bus.dout_i};
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_ONE;
        2'b01:   fifo_count <= fifo_count - CNT_ONE;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  fifo_no_overflow: assert property (@(posedge clk) disable iff (!rstn) !(push && fifo_full && !pop));

  assign bus.req_ready_o  = (state == IDLE);
  assign bus.busy_o       = (state != IDLE);
  assign bus.ren_o        = ren_q;
  assign bus.raddr_o      = raddr_q;
  assign bus.oreg_en_o    = |sh_vld;
  assign bus.data_valid_o = !fifo_empty;
  assign bus.data_o       = fifo_empty ? '0 : head[MEM_WIDTH-1:0];
  assign bus.data_last_o  = !fifo_empty && head[MEM_WIDTH];

endmodule

// File: tb/tb_vrf_read_sequencer.sv
// Randomized bench for vrf_read_sequencer: behavioural VRF with fixed read latency plus a
// burst-level scoreboard of expected addresses, words and last flags.
module tb_vrf_read_sequencer;
  localparam int MEM_DEPTH = 512;
  localparam int MEM_WIDTH = 32;
  localparam int DLY       = 4;
  localparam int FDEPTH    = 8;
  localparam int ADDR_W    = 9;
  localparam int LEN_W     = 10;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  vrf_read_sequencer_if #(.ADDR_W(ADDR_W), .MEM_WIDTH(MEM_WIDTH), .LEN_W(LEN_W)) bus ();

  vrf_read_sequencer #(
    .MEM_DEPTH(MEM_DEPTH), .MEM_WIDTH(MEM_WIDTH), .VRF_READ_DELAY(DLY), .FIFO_DEPTH(FDEPTH)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // VRF contents and its fixed-latency read pipe
  logic [MEM_WIDTH-1:0] mem [MEM_DEPTH];
  logic [DLY-1:0]       pipe_vld = '0;
  logic [ADDR_W-1:0]    pipe_addr [DLY];
  logic [MEM_WIDTH-1:0] junk = '0;
  int                   cyc = 0;

  always @(posedge clk) begin
    cyc          <= cyc + 1;
    junk         <= $urandom;
    pipe_vld[0]  <= bus.ren_o;
    pipe_addr[0] <= bus.raddr_o;
    for (int k = 1; k < DLY; k++) begin
      pipe_vld[k]  <= pipe_vld[k-1];
      pipe_addr[k] <= pipe_addr[k-1];
    end
  end

  always_comb bus.dout_i = pipe_vld[DLY-1] ? mem[pipe_addr[DLY-1]] : junk;

  // Scoreboard
  int                   exp_addr [$];
  logic [MEM_WIDTH-1:0] exp_dat  [$];
  bit                   exp_last [$];
  int  n_reads, n_beats, outstanding;
  int  first_ren, first_beat, last_beat, acc_cyc;
  bit  visited [MEM_DEPTH];

  initial begin
    forever begin
      @(negedge clk);
      if (rstn) begin
        if (bus.ren_o) begin
          if (first_ren < 0) first_ren = cyc;
          n_reads++;
          outstanding++;
          visited[bus.raddr_o] = 1'b1;
          check("credit", outstanding <= FDEPTH, 1);
          if (exp_addr.size() == 0) check("spurious_read", 1, 0);
          else check("raddr", bus.raddr_o, exp_addr.pop_front());
        end
        if (bus.data_valid_o && bus.data_ready_i) begin
          if (first_beat < 0) first_beat = cyc;
          last_beat = cyc;
          n_beats++;
          outstanding--;
          if (exp_dat.size() == 0) check("spurious_beat", 1, 0);
          else begin
            check("data", bus.data_o, exp_dat.pop_front());
            check("last", bus.data_last_o, exp_last.pop_front());
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_req(input int base, input int len);
    int waited = 0;
    while (!bus.req_ready_o && waited < 200) begin
      step();
      waited++;
    end
    check("req_ready_before_send", bus.req_ready_o, 1);
    bus.req_valid_i = 1'b1;
    bus.req_base_i  = ADDR_W'(base);
    bus.req_len_i   = LEN_W'(len);
    acc_cyc    = cyc;
    n_reads    = 0;
    n_beats    = 0;
    first_ren  = -1;
    first_beat = -1;
    last_beat  = -1;
    for (int i = 0; i < len; i++) begin
      exp_addr.push_back((base + i) % MEM_DEPTH);
      exp_dat.push_back(mem[(base + i) % MEM_DEPTH]);
      exp_last.push_back(i == len - 1);
    end
    step();
    bus.req_valid_i = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit rnd_ready);
    int k = 0;
    while ((exp_dat.size() != 0 || bus.busy_o) && k < budget) begin
      if (rnd_ready) bus.data_ready_i = 1'($urandom_range(0, 1));
      step();
      k++;
    end
    check("burst_done", (exp_dat.size() == 0) && !bus.busy_o, 1);
    bus.data_ready_i = 1'b1;
  endtask

  task automatic check_reset_outputs();
    check("rst_req_ready", bus.req_ready_o, 1);
    check("rst_ren", bus.ren_o, 0);
    check("rst_raddr", bus.raddr_o, 0);
    check("rst_oreg_en", bus.oreg_en_o, 0);
    check("rst_data_valid", bus.data_valid_o, 0);
    check("rst_data", bus.data_o, 0);
    check("rst_data_last", bus.data_last_o, 0);
    check("rst_busy", bus.busy_o, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog cycles=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int seen;
    rstn             = 1'b0;
    bus.req_valid_i  = 1'b0;
    bus.req_base_i   = '0;
    bus.req_len_i    = '0;
    bus.data_ready_i = 1'b1;
    outstanding      = 0;
    for (int i = 0; i < MEM_DEPTH; i++) mem[i] = $urandom;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs();
    step();
    rstn = 1'b1;
    step();

    // Single burst at full rate, latency checks
    send_req(9'h010, 4);
    check("busy_during", bus.busy_o, 1);
    check("req_ready_during", bus.req_ready_o, 0);
    wait_done(100, 1'b0);
    check("first_ren_cyc", first_ren, acc_cyc + 1);
    check("first_beat_cyc", first_beat, acc_cyc + DLY + 2);
    check("last_beat_cyc", last_beat, acc_cyc + DLY + 4 + 1);
    check("t1_reads", n_reads, 4);
    check("t1_beats", n_beats, 4);

    // Address wrap
    send_req(9'h1FE, 4);
    wait_done(100, 1'b0);
    check("wrap_beats", n_beats, 4);

    // Backpressure: only FIFO_DEPTH reads may go out while the stream is stalled
    bus.data_ready_i = 1'b0;
    send_req(9'h080, 20);
    repeat (30) step();
    check("bp_reads_stalled", n_reads, FDEPTH);
    check("bp_beats_stalled", n_beats, 0);
    check("bp_data_valid", bus.data_valid_o, 1);
    bus.data_ready_i = 1'b1;
    wait_done(200, 1'b0);
    check("bp_reads", n_reads, 20);
    check("bp_beats", n_beats, 20);

    // Zero-length request
    send_req(9'h055, 0);
    for (int i = 0; i < 5; i++) begin
      check("len0_busy", bus.busy_o, 0);
      check("len0_req_ready", bus.req_ready_o, 1);
      step();
    end
    check("len0_reads", n_reads, 0);
    check("len0_beats", n_beats, 0);

    // Full-RAM burst with random stream backpressure
    for (int i = 0; i < MEM_DEPTH; i++) visited[i] = 1'b0;
    send_req(int'($urandom_range(0, MEM_DEPTH - 1)), MEM_DEPTH);
    wait_done(8000, 1'b1);
    seen = 0;
    for (int i = 0; i < MEM_DEPTH; i++) seen += int'(visited[i]);
    check("full_coverage", seen, MEM_DEPTH);
    check("full_beats", n_beats, MEM_DEPTH);

    // Reset in the middle of a burst with reads in flight
    send_req(9'h100, 40);
    step();
    step();
    rstn = 1'b0;
    step();
    exp_addr.delete();
    exp_dat.delete();
    exp_last.delete();
    outstanding = 0;
    @(negedge clk);
    check_reset_outputs();
    step();
    rstn = 1'b1;
    step();
    send_req(9'h040, 6);
    wait_done(100, 1'b0);
    check("post_rst_reads", n_reads, 6);
    check("post_rst_beats", n_beats, 6);
    repeat (10) step();
    check("leftover_addr", exp_addr.size(), 0);
    check("leftover_beats", exp_dat.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
